// File: rtl/egress_byte_fifo.sv
// Egress byte FIFO: buffers 32-bit egress words and serializes them MSB first
// as a byte stream with a valid/ready handshake and a sticky overflow flag.
module egress_byte_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         Clk,
    input  logic                         ARstb,
    input  logic [DATA_WIDTH-1:0]        WriteData,
    input  logic                         WriteDataValid,
    output logic                         Ready,
    output logic [7:0]                   ED,
    output logic                         EValid,
    input  logic                         EReady,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, BYTE3} state_t;

    state_t                state;
    state_t                state_nx;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] sreg;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  xfer;
    logic                  has_word;

    assign Ready    = (Count != FULL);
    assign push     = WriteDataValid & Ready;
    // A write against a full FIFO is lost even if a pop frees a slot this edge.
    assign drop     = WriteDataValid & ~Ready;
    assign xfer     = EValid & EReady;
    assign has_word = (Count != '0);

    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (has_word) begin
                    state_nx = BYTE0;
                    pop      = 1'b1;
                end
            end
            BYTE0: if (xfer) state_nx = BYTE1;
            BYTE1: if (xfer) state_nx = BYTE2;
            BYTE2: if (xfer) state_nx = BYTE3;
            BYTE3: begin
                // Chain straight into the next word so there is no bubble.
                if (xfer) begin
                    if (has_word) begin
                        state_nx = BYTE0;
                        pop      = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Storage carries no reset; pointers and Count define what is live.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= WriteData;
    end

    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   Count <= Count + CW'(1);
                2'b01:   Count <= Count - CW'(1);
                default: Count <= Count;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb) Overflow <= 1'b0;
        else if (drop) Overflow <= 1'b1;
    end

    // ED always presents the top byte of the word loaded into sreg, shifted
    // down one byte per transfer.
    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb) begin
            sreg   <= '0;
            ED     <= 8'h00;
            EValid <= 1'b0;
        end else begin
            EValid <= (state_nx != IDLE);
            if (pop) begin
                sreg <= mem[rd_ptr];
                ED   <= mem[rd_ptr][DATA_WIDTH-1 -: 8];
            end else if (xfer && state != BYTE3) begin
                sreg <= sreg << 8;
                ED   <= sreg[DATA_WIDTH-9 -: 8];
            end
        end
    end

endmodule
